// File: rtl/change_dispenser.sv
// change_dispenser: pays out change one coin at a time over a req/ack
// handshake with the coin hopper, largest denomination first.
//
// Flow: IDLE -> SELECT -> REQ -> WAIT_REL -> SELECT ... -> DONE -> IDLE.
// A hopper that never acknowledges within ACK_TIMEOUT cycles drives the
// block into ERR, which leaves a sticky err flag and the unpaid amount.
//
// Build option: CHANGE_RETRY_EN
//   undefined (default) - the first acknowledge timeout is a fault.
//   defined             - the first timeout of a coin attempt drops coin_req
//                         for one cycle and retries the same coin; only a
//                         second consecutive timeout is a fault.
//
// Every output is a flop; remain doubles as the display value while paying.

module change_dispenser #(
  parameter int AMT_W       = 6,
  parameter int COIN_HI     = 10,
  parameter int COIN_MID    = 5,
  parameter int COIN_LO     = 1,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             coin_ack,
  output logic             coin_req,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remain,
  output logic [3:0]       coins_out
);

  // Timeout counter only has to reach ACK_TIMEOUT-1 before it trips.
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [AMT_W-1:0] HI_V     = AMT_W'(COIN_HI);
  localparam logic [AMT_W-1:0] MID_V    = AMT_W'(COIN_MID);
  localparam logic [AMT_W-1:0] LO_V     = AMT_W'(COIN_LO);
  localparam logic [AMT_W-1:0] AMT_ZERO = {AMT_W{1'b0}};

  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  localparam logic [1:0] SEL_LO  = 2'd0;
  localparam logic [1:0] SEL_MID = 2'd1;
  localparam logic [1:0] SEL_HI  = 2'd2;

  localparam logic [3:0] COINS_MAX = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SELECT   = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT_REL = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  // Value in currency units of the coin encoded by sel.
  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] sel);
    case (sel)
      SEL_HI:  coin_value = HI_V;
      SEL_MID: coin_value = MID_V;
      SEL_LO:  coin_value = LO_V;
      default: coin_value = AMT_ZERO;
    endcase
  endfunction

  // Greedy pick: largest coin that still fits into the owed amount.
  // Because the pick never exceeds amt, remain can never underflow.
  function automatic logic [1:0] pick_coin(input logic [AMT_W-1:0] amt);
    if (amt >= HI_V) begin
      pick_coin = SEL_HI;
    end else if (amt >= MID_V) begin
      pick_coin = SEL_MID;
    end else begin
      pick_coin = SEL_LO;
    end
  endfunction

  // Coin count that sticks at its maximum instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    if (cnt == COINS_MAX) begin
      sat_inc = COINS_MAX;
    end else begin
      sat_inc = cnt + 4'd1;
    end
  endfunction

  state_t            state_q,     state_d;
  logic              coin_req_q,  coin_req_d;
  logic [1:0]        coin_sel_q,  coin_sel_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  logic [AMT_W-1:0]  remain_q,    remain_d;
  logic [3:0]        coins_out_q, coins_out_d;
  logic [TMO_W-1:0]  tmo_q,       tmo_d;
`ifdef CHANGE_RETRY_EN
  // Set once the current coin has already used its single retry.
  logic              retry_used_q, retry_used_d;
`endif

  // Next-state and next-output logic for the payout sequencer.
  always_comb begin
    state_d      = state_q;
    coin_req_d   = coin_req_q;
    coin_sel_d   = coin_sel_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    remain_d     = remain_q;
    coins_out_d  = coins_out_q;
    tmo_d        = tmo_q;
`ifdef CHANGE_RETRY_EN
    retry_used_d = retry_used_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remain_d     = change_amt;
          coins_out_d  = 4'd0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
`ifdef CHANGE_RETRY_EN
          retry_used_d = 1'b0;
`endif
          state_d      = S_SELECT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SELECT: begin
        if (remain_q == AMT_ZERO) begin
          // Nothing (left) to pay: one-cycle done, busy drops with it.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          coin_sel_d = pick_coin(remain_q);
          coin_req_d = 1'b1;
          tmo_d      = TMO_ZERO;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        if (coin_ack) begin
          remain_d     = remain_q - coin_value(coin_sel_q);
          coins_out_d  = sat_inc(coins_out_q);
          coin_req_d   = 1'b0;
`ifdef CHANGE_RETRY_EN
          retry_used_d = 1'b0;
`endif
          state_d      = S_WAIT_REL;
        end else if (tmo_q == TMO_LAST) begin
          coin_req_d = 1'b0;
`ifdef CHANGE_RETRY_EN
          if (!retry_used_q) begin
            // Retry through SELECT: remain is unchanged, so the same coin
            // is picked again, coin_req is low for exactly one cycle and
            // the counter restarts on re-entry to REQ.
            retry_used_d = 1'b1;
            state_d      = S_SELECT;
          end else begin
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_ERR;
          end
`else
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
`endif
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      S_WAIT_REL: begin
        // A long ack is counted once; wait for the hopper to let go.
        if (!coin_ack) begin
          state_d = S_SELECT;
        end else begin
          state_d = S_WAIT_REL;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_ERR: begin
        // err and the unpaid remain stay put until the next start.
        state_d = S_IDLE;
      end

      default: begin
        coin_req_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      coin_req_q   <= 1'b0;
      coin_sel_q   <= SEL_LO;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      remain_q     <= AMT_ZERO;
      coins_out_q  <= 4'd0;
      tmo_q        <= TMO_ZERO;
`ifdef CHANGE_RETRY_EN
      retry_used_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      coin_req_q   <= coin_req_d;
      coin_sel_q   <= coin_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      remain_q     <= remain_d;
      coins_out_q  <= coins_out_d;
      tmo_q        <= tmo_d;
`ifdef CHANGE_RETRY_EN
      retry_used_q <= retry_used_d;
`endif
    end
  end

  assign coin_req  = coin_req_q;
  assign coin_sel  = coin_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign remain    = remain_q;
  assign coins_out = coins_out_q;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Sequences change return for the vending datapath. When the purchase FSM finishes a sale, it pulses start with the residual coin sum. This block then issues coins one at a time to the coin hopper over a req/ack handshake, largest denomination first, and reports completion or a hopper fault. It drives the charge path and sits beside the FSM, with remain feeding the digit decoder while change is being paid.

Parameters:
AMT_W, 6, width of change amount and remain
COIN_HI, 10, value of high denomination (coin_sel=2)
COIN_MID, 5, value of mid denomination (coin_sel=1)
COIN_LO, 1, value of low denomination (coin_sel=0)
ACK_TIMEOUT, 15, cycles coin_req may stay unacknowledged before fault

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active high
start  in  1  single-cycle request to pay change_amt
change_amt  in  AMT_W  amount to return; sampled only when start is accepted
coin_ack  in  1  hopper acknowledge; level, high once coin is ejected
coin_req  out  1  request one coin of denomination coin_sel
coin_sel  out  2  0=LO, 1=MID, 2=HI; 3 never driven
busy  out  1  high from accepted start until DONE/ERR
done  out  1  single-cycle pulse when remain reaches 0
err  out  1  sticky hopper fault flag
remain  out  AMT_W  change still owed
coins_out  out  4  coins issued this transaction, saturating at 15

Behaviour:
- Reset (clk edge with rst=1): state IDLE. All outputs 0. Timeout counter 0. Reset overrides everything. Mid-transaction reset drops coin_req on that same edge and discards remain.
- States: IDLE, SELECT, REQ, WAIT_REL, DONE, ERR. All outputs are registered.
- IDLE:
  - start=1 latches remain<=change_amt, clears coins_out and err, and moves to SELECT. busy=1 from the next cycle.
  - start with change_amt=0 still goes through SELECT, which sends it straight to DONE with no coin_req.
- SELECT (1 cycle):
  - remain==0 -> DONE.
  - Otherwise coin_sel <= 2 if remain>=COIN_HI, else 1 if remain>=COIN_MID, else 0. Then go to REQ. coin_req=1 is visible on the cycle after SELECT.
- REQ:
  - coin_req=1 and coin_sel held stable.
  - On an edge with coin_ack=1: remain <= remain - value(coin_sel), coins_out increments (saturating), coin_req deasserts, go to WAIT_REL.
  - Timeout counter increments on each REQ cycle without ack. Reaching ACK_TIMEOUT -> ERR.
  - Counter clears on entry to REQ.
- WAIT_REL: wait for coin_ack=0, then go to SELECT. An ack held high never double-counts a coin.
- DONE (1 cycle): done=1, busy=0. Next state IDLE.
- ERR: coin_req=0, busy=0, err=1. remain holds the unpaid amount. Next state IDLE. err stays high until the next accepted start or rst.
- start outside IDLE is ignored. coin_ack outside REQ/WAIT_REL is ignored.
- Subtraction never underflows: the greedy selection guarantees value(coin_sel) <= remain.
- Latency: for nonzero amount, start edge t gives coin_req=1 at t+2. Minimum per coin is 3 cycles (REQ, WAIT_REL, SELECT) when ack is 1 cycle wide.

Optional Feature:
- Macro: CHANGE_RETRY_EN.
- Defined: the first timeout in a coin attempt drops coin_req for 1 cycle, then re-enters REQ with a cleared counter and the same coin_sel. Only the second consecutive timeout for that coin goes to ERR. The retry budget resets on every accepted ack.
- Undefined: the first timeout goes to ERR, as described above.

Test Plan:
- change_amt=17, ack 1 cycle after each req -> coin_sel sequence 2,1,0,0; coins_out=4; remain 17->7->2->1->0; one done pulse; busy falls with done.
- change_amt=0 -> done pulse 2 cycles after start; coin_req never asserted; coins_out=0.
- change_amt=5, coin_ack never asserted -> coin_req high for 15 cycles, then err=1, busy=0, remain=5. With CHANGE_RETRY_EN: req low 1 cycle, second 15-cycle window, then err.
- change_amt=10, coin_ack held high 4 cycles -> exactly 1 coin counted; remain=0; done after ack falls.
- rst asserted while in REQ during change_amt=20 -> coin_req=0 on the reset edge; all outputs 0; a following start with 6 pays 5,1 normally.
- Second start pulse mid-transaction (change_amt=13 active, start with 40) -> ignored; only 13 paid (10,1,1,1).
